turfio_aurora_link_sequencer: RTL and testbench
===============================================

Name: turfio_aurora_link_sequencer

Overview:
Init-clock-domain controller that brings up and supervises one TURFIO Aurora link. Sequences GT PMA init, waits for GT clock lock, pulses the BUFG_GT clear of the link clock module, and releases the Aurora reset. Monitors channel-up and retries with timeouts on any failure. Sits beside the TURFIO Aurora clock module and drives its clear input from the free-running init clock.

Parameters:
PMA_INIT_CYCLES, 1024, init_clk cycles pma_init_o held high per attempt (>=1)
CLR_CYCLES, 16, init_clk cycles bufg_gt_clr_o held high (>=1)
LOCK_TIMEOUT, 65536, max cycles in WAIT_LOCK or WAIT_CLK before retry
CHAN_TIMEOUT, 1048576, max cycles in WAIT_CHAN before retry
CNT_W, 21, width of shared state counter; must hold max(all above)

Ports:
init_clk_i  in  1  free-running init clock; all logic in this domain
init_rst_n_i  in  1  asynchronous, active-low reset
enable_i  in  1  level; low forces IDLE with all resets asserted
restart_i  in  1  single-cycle pulse; forces new attempt without counting a retry
gt_clk_locked_i  in  1  GT PLL lock, async; 2-FF synchronized
pll_not_locked_i  in  1  from Aurora clock module, async; 2-FF synchronized
channel_up_i  in  1  Aurora channel_up (user_clk domain); 2-FF synchronized
pma_init_o  out  1  GT PMA init
bufg_gt_clr_o  out  1  to clock module BUFG_GT clear
reset_pb_o  out  1  Aurora reset pushbutton
link_up_o  out  1  high only in RUNNING
state_o  out  3  current state encoding
retry_count_o  out  8  failed attempts, saturating

Behaviour:
- Reset (init_rst_n_i low, asynchronous): state IDLE; pma_init_o=1, bufg_gt_clr_o=1, reset_pb_o=1, link_up_o=0, retry_count_o=0, counter=0, synchronizer flops=0.
- All outputs are registered and Moore-style: each output reflects the current state and changes on the same edge as the state register.
- Synchronized inputs lag their pins by 2 cycles. All tests below use synchronized values.
- Encodings: IDLE=0, PMA_INIT=1, WAIT_LOCK=2, CLK_CLR=3, WAIT_CLK=4, WAIT_CHAN=5, RUNNING=6.
- Output per state (pma_init/clr/reset_pb/link_up):
  - IDLE and PMA_INIT: 1/1/1/0
  - WAIT_LOCK: 0/1/1/0
  - CLK_CLR: 0/1/1/0
  - WAIT_CLK: 0/0/1/0
  - WAIT_CHAN: 0/0/0/0
  - RUNNING: 0/0/0/1
- Counter clears on every state change. Otherwise it increments each cycle, saturating at all-ones.
- IDLE: if enable_i is high, go to PMA_INIT.
- PMA_INIT: once counter == PMA_INIT_CYCLES-1, go to WAIT_LOCK. The state therefore lasts exactly PMA_INIT_CYCLES cycles.
- WAIT_LOCK:
  - lock_sync high: go to CLK_CLR.
  - else counter == LOCK_TIMEOUT-1: fail.
- CLK_CLR: once counter == CLR_CYCLES-1, go to WAIT_CLK. bufg_gt_clr_o is high for exactly CLR_CYCLES cycles after lock.
- WAIT_CLK:
  - pnl_sync low: go to WAIT_CHAN.
  - else counter == LOCK_TIMEOUT-1: fail.
- WAIT_CHAN:
  - chan_sync high: go to RUNNING.
  - else lock_sync low, or counter == CHAN_TIMEOUT-1: fail.
- RUNNING: chan_sync low, lock_sync low, or pnl_sync high: fail.
- Fail: go to PMA_INIT and increment retry_count_o, saturating at 255.
- Priority, highest first:
  1. enable_i low: go to IDLE from any state. No retry increment; retry_count_o holds.
  2. restart_i high while enabled: go to PMA_INIT, no increment, even if a fail condition coincides. In PMA_INIT it restarts the counter.
  3. Fail or timeout.
  4. Normal advance.
- retry_count_o clears only on init_rst_n_i.
- Lock success and timeout on the same cycle: success wins.

Test Plan:
All tests use PMA_INIT_CYCLES=4, CLR_CYCLES=2, LOCK_TIMEOUT=16, CHAN_TIMEOUT=32.

- Nominal bring-up: release reset, enable=1, lock high at t0, pnl low after clr, chan_up high. Required: pma_init high for 4 cycles; clr high for 2 cycles after lock_sync; reset_pb falls on entry to WAIT_CHAN; link_up=1; state_o=6; retry=0.
- Lock timeout: lock held low. Required: WAIT_LOCK lasts 16 cycles, then PMA_INIT with retry=1. After 3 loops, retry=3; outputs follow the per-state table throughout.
- Channel drop in RUNNING: deassert channel_up for 1 cycle. Required: 2 cycles later state=PMA_INIT, link_up=0, all of pma_init/clr/reset_pb =1, retry increments by 1.
- Restart with simultaneous fail: in WAIT_CHAN pulse restart_i on the same cycle the timeout fires. Required: PMA_INIT with retry unchanged.
- Enable drop: drop enable mid WAIT_CLK. Required: next cycle IDLE (state_o=0), all resets 1, retry held. Re-enable restarts from PMA_INIT.
- Async reset and saturation: force 300 lock timeouts, then check retry=255. Assert init_rst_n_i mid CLK_CLR, then check outputs at reset values immediately without a clock edge.

Source files
------------

// File: rtl/turfio_aurora_link_sequencer_if.sv
// Control/status bundle between the TURFIO Aurora link sequencer and the GT/Aurora side.
// The master modport is the sequencer; the slave modport is whoever drives the status pins.
interface turfio_aurora_link_sequencer_if;
   logic       enable_i;
   logic       restart_i;
   logic       gt_clk_locked_i;
   logic       pll_not_locked_i;
   logic       channel_up_i;
   logic       pma_init_o;
   logic       bufg_gt_clr_o;
   logic       reset_pb_o;
   logic       link_up_o;
   logic [2:0] state_o;
   logic [7:0] retry_count_o;

   modport master (
      input  enable_i, restart_i, gt_clk_locked_i, pll_not_locked_i, channel_up_i,
      output pma_init_o, bufg_gt_clr_o, reset_pb_o, link_up_o, state_o, retry_count_o
   );

   modport slave (
      output enable_i, restart_i, gt_clk_locked_i, pll_not_locked_i, channel_up_i,
      input  pma_init_o, bufg_gt_clr_o, reset_pb_o, link_up_o, state_o, retry_count_o
   );
endinterface

// File: rtl/turfio_aurora_link_sequencer.sv
// Init-clock-domain bring-up/supervision sequencer for one TURFIO Aurora link:
// PMA init, GT lock wait, BUFG_GT clear pulse, Aurora reset release, retry on failure.
module turfio_aurora_link_sequencer #(
   parameter int unsigned PMA_INIT_CYCLES = 1024,
   parameter int unsigned CLR_CYCLES      = 16,
   parameter int unsigned LOCK_TIMEOUT    = 65536,
   parameter int unsigned CHAN_TIMEOUT    = 1048576,
   parameter int unsigned CNT_W           = 21
) (
   input  logic                           init_clk_i,
   input  logic                           init_rst_n_i,
   turfio_aurora_link_sequencer_if.master link
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StPmaInit  = 3'd1,
      StWaitLock = 3'd2,
      StClkClr   = 3'd3,
      StWaitClk  = 3'd4,
      StWaitChan = 3'd5,
      StRunning  = 3'd6
   } state_e;

   localparam logic [CNT_W-1:0] PmaLast  = CNT_W'(PMA_INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ClrLast  = CNT_W'(CLR_CYCLES - 1);
   localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ChanLast = CNT_W'(CHAN_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       retry_q, retry_d;
   logic [1:0]       lock_ff, pnl_ff, chan_ff;
   logic             lock_sync, pnl_sync, chan_sync;
   logic             fail, cnt_clr;
   logic             pma_init_q, clr_q, reset_pb_q, link_up_q;
   logic             pma_init_d, clr_d, reset_pb_d, link_up_d;

   // Two-flop synchronizers for the asynchronous status inputs.
   always_ff @(posedge init_clk_i or negedge init_rst_n_i) begin
      if (!init_rst_n_i) begin
         lock_ff <= 2'b00;
         pnl_ff  <= 2'b00;
         chan_ff <= 2'b00;
      end else begin
         lock_ff <= {lock_ff[0], link.gt_clk_locked_i};
         pnl_ff  <= {pnl_ff[0], link.pll_not_locked_i};
         chan_ff <= {chan_ff[0], link.channel_up_i};
      end
   end

   assign lock_sync = lock_ff[1];
   assign pnl_sync  = pnl_ff[1];
   assign chan_sync = chan_ff[1];

   // State, counter, retry count and the registered Moore outputs.
   always_ff @(posedge init_clk_i or negedge init_rst_n_i) begin
      if (!init_rst_n_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         retry_q    <= 8'd0;
         pma_init_q <= 1'b1;
         clr_q      <= 1'b1;
         reset_pb_q <= 1'b1;
         link_up_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         pma_init_q <= pma_init_d;
         clr_q      <= clr_d;
         reset_pb_q <= reset_pb_d;
         link_up_q  <= link_up_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fail    = 1'b0;
      cnt_clr = 1'b0;
      if (!link.enable_i) begin
         state_d = StIdle;
      end else if (link.restart_i) begin
         // Restart overrides any coincident failure and always restarts the count.
         state_d = StPmaInit;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            StIdle:     state_d = StPmaInit;
            StPmaInit:  if (cnt_q == PmaLast) state_d = StWaitLock;
            StWaitLock: begin
               if (lock_sync) state_d = StClkClr;
               else if (cnt_q == LockLast) fail = 1'b1;
            end
            StClkClr:   if (cnt_q == ClrLast) state_d = StWaitClk;
            StWaitClk: begin
               if (!pnl_sync) state_d = StWaitChan;
               else if (cnt_q == LockLast) fail = 1'b1;
            end
            StWaitChan: begin
               if (chan_sync) state_d = StRunning;
               else if (!lock_sync || cnt_q == ChanLast) fail = 1'b1;
            end
            StRunning:  if (!chan_sync || !lock_sync || pnl_sync) fail = 1'b1;
            default:    state_d = StIdle;
         endcase
         if (fail) state_d = StPmaInit;
      end
      if (state_d != state_q) cnt_clr = 1'b1;
      cnt_d   = cnt_clr ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
      retry_d = (fail && retry_q != 8'hff) ? retry_q + 8'd1 : retry_q;
   end

   // Outputs decoded from the next state so they move on the same edge as the state.
   always_comb begin
      pma_init_d = 1'b0;
      clr_d      = 1'b0;
      reset_pb_d = 1'b0;
      link_up_d  = 1'b0;
      case (state_d)
         StIdle, StPmaInit: begin
            pma_init_d = 1'b1;
            clr_d      = 1'b1;
            reset_pb_d = 1'b1;
         end
         StWaitLock, StClkClr: begin
            clr_d      = 1'b1;
            reset_pb_d = 1'b1;
         end
         StWaitClk:  reset_pb_d = 1'b1;
         StWaitChan: link_up_d  = 1'b0;
         StRunning:  link_up_d  = 1'b1;
         default: begin
            pma_init_d = 1'b1;
            clr_d      = 1'b1;
            reset_pb_d = 1'b1;
         end
      endcase
   end

   assign link.pma_init_o    = pma_init_q;
   assign link.bufg_gt_clr_o = clr_q;
   assign link.reset_pb_o    = reset_pb_q;
   assign link.link_up_o     = link_up_q;
   assign link.state_o       = state_q;
   assign link.retry_count_o = retry_q;

endmodule

// File: tb/tb_turfio_aurora_link_sequencer.sv
// Self-checking bench for turfio_aurora_link_sequencer: table-driven reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_turfio_aurora_link_sequencer;
   localparam int P_CYC = 4;
   localparam int C_CYC = 2;
   localparam int L_TMO = 16;
   localparam int C_TMO = 32;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   seen [8];

   turfio_aurora_link_sequencer_if link ();

   turfio_aurora_link_sequencer #(
      .PMA_INIT_CYCLES (P_CYC),
      .CLR_CYCLES      (C_CYC),
      .LOCK_TIMEOUT    (L_TMO),
      .CHAN_TIMEOUT    (C_TMO),
      .CNT_W           (8)
   ) dut (
      .init_clk_i   (clk),
      .init_rst_n_i (rst_n),
      .link         (link)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per-state dwell/timeout tables, states advance in ordinal order,
   // any failure returns to PMA_INIT (1). Outputs {pma_init, clr, reset_pb, link_up}.
   int       dur_tbl [0:6] = '{0, P_CYC, 0, C_CYC, 0, 0, 0};
   int       tmo_tbl [0:6] = '{0, 0, L_TMO, 0, L_TMO, C_TMO, 0};
   bit [3:0] out_tbl [0:6] = '{4'b1110, 4'b1110, 4'b0110, 4'b0110, 4'b0010, 4'b0000, 4'b0001};

   typedef struct packed {
      logic       fail;
      logic [2:0] st;
   } step_t;

   int    m_state, m_age, m_retry;
   bit [1:0] lk_h, pn_h, ch_h;
   step_t m_step;

   function automatic step_t model_step(int s, int age, bit en, bit rs, bit lk, bit pn, bit ch);
      step_t r;
      bit    adv;
      bit    tmo;
      r.fail = 1'b0;
      r.st   = 3'(s);
      adv    = 1'b0;
      tmo    = (age + 1 == tmo_tbl[s]);
      if (!en) r.st = 3'd0;
      else if (rs) r.st = 3'd1;
      else begin
         case (s)
            0:       adv = 1'b1;
            1, 3:    adv = (age + 1 == dur_tbl[s]);
            2:       begin adv = lk; r.fail = !lk && tmo; end
            4:       begin adv = !pn; r.fail = pn && tmo; end
            5:       begin adv = ch; r.fail = !ch && (!lk || tmo); end
            default: r.fail = !ch || !lk || pn;
         endcase
         if (r.fail) r.st = 3'd1;
         else if (adv) r.st = 3'(s + 1);
      end
      return r;
   endfunction

   always_comb m_step = model_step(m_state, m_age, link.enable_i, link.restart_i,
                                   lk_h[1], pn_h[1], ch_h[1]);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         m_age   <= 0;
         m_retry <= 0;
         lk_h    <= 2'b00;
         pn_h    <= 2'b00;
         ch_h    <= 2'b00;
      end else begin
         m_state <= int'(m_step.st);
         m_age   <= (int'(m_step.st) != m_state || (link.enable_i && link.restart_i)) ?
                    0 : m_age + 1;
         if (m_step.fail && m_retry < 255) m_retry <= m_retry + 1;
         lk_h <= {lk_h[0], link.gt_clk_locked_i};
         pn_h <= {pn_h[0], link.pll_not_locked_i};
         ch_h <= {ch_h[0], link.channel_up_i};
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("model_state", int'(link.state_o), m_state);
         check("model_outputs", int'({link.pma_init_o, link.bufg_gt_clr_o, link.reset_pb_o,
                                      link.link_up_o}), int'(out_tbl[m_state]));
         check("model_retry", int'(link.retry_count_o), m_retry);
      end
   end

   // Called at a negedge; tallies the states seen until the target state is reached.
   task automatic wait_state(input int target, input int budget);
      int n = 0;
      while (int'(link.state_o) != target && n < budget) begin
         seen[link.state_o]++;
         n++;
         @(negedge clk);
      end
      check($sformatf("reach_state_%0d", target), int'(link.state_o), target);
   endtask

   task automatic clear_seen();
      for (int i = 0; i < 8; i++) seen[i] = 0;
   endtask

   task automatic check_resets(input string name, input int exp);
      check(name, int'({link.pma_init_o, link.bufg_gt_clr_o, link.reset_pb_o, link.link_up_o}),
            exp);
   endtask

   initial begin
      rst_n                 = 1'b0;
      link.enable_i         = 1'b0;
      link.restart_i        = 1'b0;
      link.gt_clk_locked_i  = 1'b0;
      link.pll_not_locked_i = 1'b0;
      link.channel_up_i     = 1'b0;
      #7;
      check("reset_state", int'(link.state_o), 0);
      check_resets("reset_outputs", 4'b1110);
      check("reset_retry", int'(link.retry_count_o), 0);

      // Nominal bring-up
      @(negedge clk);
      link.enable_i         = 1'b1;
      link.gt_clk_locked_i  = 1'b1;
      link.pll_not_locked_i = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      clear_seen();
      wait_state(2, 20);
      check("pma_init_cycles", seen[1], 4);
      clear_seen();
      wait_state(4, 20);
      check("wait_lock_cycles", seen[2], 1);
      check("clk_clr_cycles", seen[3], 2);
      check_resets("wait_clk_outputs", 4'b0010);
      link.pll_not_locked_i = 1'b0;
      @(negedge clk);
      wait_state(5, 10);
      check_resets("wait_chan_outputs", 4'b0000);
      link.channel_up_i = 1'b1;
      @(negedge clk);
      wait_state(6, 10);
      check("nominal_link_up", int'(link.link_up_o), 1);
      check("nominal_retry", int'(link.retry_count_o), 0);

      // Channel drop for one cycle
      repeat (3) @(negedge clk);
      link.channel_up_i = 1'b0;
      @(negedge clk);
      link.channel_up_i = 1'b1;
      repeat (2) @(negedge clk);
      check("chan_drop_state", int'(link.state_o), 1);
      check_resets("chan_drop_outputs", 4'b1110);
      check("chan_drop_retry", int'(link.retry_count_o), 1);
      wait_state(6, 40);

      // Lock loss in RUNNING, then three lock timeouts
      link.gt_clk_locked_i = 1'b0;
      @(negedge clk);
      wait_state(1, 10);
      check("lock_loss_retry", int'(link.retry_count_o), 2);
      for (int i = 0; i < 3; i++) begin
         wait_state(2, 10);
         clear_seen();
         wait_state(1, 30);
         check("lock_timeout_len", seen[2], 16);
         check("lock_timeout_retry", int'(link.retry_count_o), 3 + i);
      end
      check("three_timeouts_retry", int'(link.retry_count_o), 5);

      // Restart on the same cycle as the WAIT_CHAN timeout
      link.gt_clk_locked_i = 1'b1;
      link.channel_up_i    = 1'b0;
      wait_state(5, 40);
      repeat (31) @(negedge clk);
      link.restart_i = 1'b1;
      @(negedge clk);
      link.restart_i = 1'b0;
      check("restart_state", int'(link.state_o), 1);
      check("restart_retry", int'(link.retry_count_o), 5);

      // Enable drop in WAIT_CLK
      link.pll_not_locked_i = 1'b1;
      wait_state(4, 20);
      @(negedge clk);
      link.enable_i = 1'b0;
      @(negedge clk);
      check("disable_state", int'(link.state_o), 0);
      check_resets("disable_outputs", 4'b1110);
      check("disable_retry", int'(link.retry_count_o), 5);
      link.enable_i = 1'b1;
      @(negedge clk);
      check("reenable_state", int'(link.state_o), 1);

      // 300 lock timeouts saturate the retry count
      link.gt_clk_locked_i = 1'b0;
      repeat (300 * (P_CYC + L_TMO)) @(negedge clk);
      check("retry_saturated", int'(link.retry_count_o), 255);

      // Asynchronous reset mid CLK_CLR
      link.gt_clk_locked_i = 1'b1;
      wait_state(3, 40);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_state", int'(link.state_o), 0);
      check_resets("async_reset_outputs", 4'b1110);
      check("async_reset_retry", int'(link.retry_count_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
